// File: rtl/pingpong_sym_reader.sv
// Read side of the modulation-symbol ping-pong buffer: queues completed banks,
// reads them from the symbol RAMs and streams I/Q over valid/ready.
//
// state | meaning
// IDLE  | wait for a queued bank, pop its length
// READ  | issue RAM reads under the output-buffer credit limit
// DRAIN | wait for the last-tagged sample to be accepted, then free the bank
module pingpong_sym_reader #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_SYMS   = 1200
) (
  input  logic                         CLK_Rd,
  input  logic                         RST_Rd,
  input  logic                         Bank_Ready,
  input  logic [ADDR_WIDTH-1:0]        Bank_Len,
  output logic                         Rd_en,
  output logic [ADDR_WIDTH-1:0]        Rd_addr,
  output logic                         Bank_Sel,
  input  logic signed [DATA_WIDTH-1:0] Rd_data_I,
  input  logic signed [DATA_WIDTH-1:0] Rd_data_Q,
  output logic signed [DATA_WIDTH-1:0] Out_I,
  output logic signed [DATA_WIDTH-1:0] Out_Q,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic                         Out_Last,
  output logic                         Bank_Free,
  output logic                         Overrun
);

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MAX_SYMS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] len_mem [2];
  logic                  len_wr_ptr, len_rd_ptr;
  logic [1:0]            len_cnt;
  logic [1:0]            pending;

  logic [ADDR_WIDTH-1:0] addr_cnt, remain_cnt;
  logic                  bank_sel_q, bank_free_q, overrun_q;
  logic                  rd_pend_q, rd_last_q;

  logic signed [DATA_WIDTH-1:0] ob_i [2];
  logic signed [DATA_WIDTH-1:0] ob_q [2];
  logic                         ob_last [2];
  logic                         ob_wr_ptr, ob_rd_ptr;
  logic [1:0]                   ob_cnt;

  logic [ADDR_WIDTH-1:0] len_in;
  logic                  push_ok, pop_len, rd_issue, free_set, out_pop;
  logic [2:0]            credit_used;

  assign len_in  = (Bank_Len > MAX_LEN) ? MAX_LEN : Bank_Len;
  // A bank released in the same cycle makes room for the incoming one
  assign push_ok = Bank_Ready && ((pending != 2'd2) || bank_free_q);

  assign Out_Valid = (ob_cnt != 2'd0);
  assign Out_I     = ob_i[ob_rd_ptr];
  assign Out_Q     = ob_q[ob_rd_ptr];
  assign Out_Last  = Out_Valid && ob_last[ob_rd_ptr];
  assign out_pop   = Out_Valid && Out_Ready;

  // Buffer slots committed after this cycle's pop; keeps 1 sample/cycle flow
  assign credit_used = {1'b0, ob_cnt} + {2'b00, rd_pend_q} - {2'b00, out_pop};

  assign Rd_en     = rd_issue;
  assign Rd_addr   = addr_cnt;
  assign Bank_Sel  = bank_sel_q;
  assign Bank_Free = bank_free_q;
  assign Overrun   = overrun_q;

  always_ff @(posedge CLK_Rd) begin
    if (RST_Rd) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_len   = 1'b0;
    rd_issue  = 1'b0;
    free_set  = 1'b0;
    case (state)
      S_IDLE: begin
        if ((len_cnt != 2'd0) && !bank_free_q) begin
          pop_len = 1'b1;
          if (len_mem[len_rd_ptr] == '0) free_set  = 1'b1;
          else                           state_nxt = S_READ;
        end
      end
      S_READ: begin
        if ((remain_cnt != '0) && (credit_used < 3'd2)) begin
          rd_issue = 1'b1;
          if (remain_cnt == ADDR_WIDTH'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_pop && Out_Last) begin
          free_set  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_Rd) begin
    if (RST_Rd) begin
      len_mem[0] <= '0;
      len_mem[1] <= '0;
      len_wr_ptr <= 1'b0;
      len_rd_ptr <= 1'b0;
      len_cnt    <= 2'd0;
      pending    <= 2'd0;
      overrun_q  <= 1'b0;
    end else begin
      if (push_ok) begin
        len_mem[len_wr_ptr] <= len_in;
        len_wr_ptr          <= ~len_wr_ptr;
      end
      if (pop_len) len_rd_ptr <= ~len_rd_ptr;
      case ({push_ok, pop_len})
        2'b10:   len_cnt <= len_cnt + 2'd1;
        2'b01:   len_cnt <= len_cnt - 2'd1;
        default: len_cnt <= len_cnt;
      endcase
      // pending covers queued banks plus the one being read, until released
      case ({push_ok, bank_free_q})
        2'b10:   pending <= pending + 2'd1;
        2'b01:   pending <= pending - 2'd1;
        default: pending <= pending;
      endcase
      if (Bank_Ready && (pending == 2'd2) && !bank_free_q) overrun_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK_Rd) begin
    if (RST_Rd) begin
      addr_cnt    <= '0;
      remain_cnt  <= '0;
      bank_sel_q  <= 1'b0;
      bank_free_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      bank_free_q <= free_set;
      if (free_set) bank_sel_q <= ~bank_sel_q;
      if (pop_len) begin
        addr_cnt   <= '0;
        remain_cnt <= len_mem[len_rd_ptr];
      end else if (rd_issue) begin
        remain_cnt <= remain_cnt - ADDR_WIDTH'(1);
        // Hold the address on the final read so it never passes length-1
        if (remain_cnt != ADDR_WIDTH'(1)) addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
      end
      rd_pend_q <= rd_issue;
      rd_last_q <= rd_issue && (remain_cnt == ADDR_WIDTH'(1));
    end
  end

  always_ff @(posedge CLK_Rd) begin
    if (RST_Rd) begin
      ob_i[0]    <= '0;
      ob_i[1]    <= '0;
      ob_q[0]    <= '0;
      ob_q[1]    <= '0;
      ob_last[0] <= 1'b0;
      ob_last[1] <= 1'b0;
      ob_wr_ptr  <= 1'b0;
      ob_rd_ptr  <= 1'b0;
      ob_cnt     <= 2'd0;
    end else begin
      if (rd_pend_q) begin
        ob_i[ob_wr_ptr]    <= Rd_data_I;
        ob_q[ob_wr_ptr]    <= Rd_data_Q;
        ob_last[ob_wr_ptr] <= rd_last_q;
        ob_wr_ptr          <= ~ob_wr_ptr;
      end
      if (out_pop) ob_rd_ptr <= ~ob_rd_ptr;
      case ({rd_pend_q, out_pop})
        2'b10:   ob_cnt <= ob_cnt + 2'd1;
        2'b01:   ob_cnt <= ob_cnt - 2'd1;
        default: ob_cnt <= ob_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_sym_reader.sv
// Randomized bench for pingpong_sym_reader: banks are expanded into an
// expected sample stream and read-address sequence from RAM images.
module tb_pingpong_sym_reader;

  localparam int DW = 18;
  localparam int AW = 11;
  localparam int MAXS = 1200;

  logic                 CLK_Rd = 1'b0;
  logic                 RST_Rd = 1'b1;
  logic                 Bank_Ready = 1'b0;
  logic [AW-1:0]        Bank_Len = '0;
  logic                 Rd_en;
  logic [AW-1:0]        Rd_addr;
  logic                 Bank_Sel;
  logic signed [DW-1:0] Rd_data_I;
  logic signed [DW-1:0] Rd_data_Q;
  logic signed [DW-1:0] Out_I;
  logic signed [DW-1:0] Out_Q;
  logic                 Out_Valid;
  logic                 Out_Ready = 1'b0;
  logic                 Out_Last;
  logic                 Bank_Free;
  logic                 Overrun;

  pingpong_sym_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_SYMS(MAXS)) dut (
    .CLK_Rd(CLK_Rd), .RST_Rd(RST_Rd), .Bank_Ready(Bank_Ready), .Bank_Len(Bank_Len),
    .Rd_en(Rd_en), .Rd_addr(Rd_addr), .Bank_Sel(Bank_Sel),
    .Rd_data_I(Rd_data_I), .Rd_data_Q(Rd_data_Q),
    .Out_I(Out_I), .Out_Q(Out_Q), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Last(Out_Last), .Bank_Free(Bank_Free), .Overrun(Overrun)
  );

  always #5 CLK_Rd = ~CLK_Rd;

  typedef struct {
    logic signed [DW-1:0] i_v;
    logic signed [DW-1:0] q_v;
    logic                 last;
  } samp_t;

  typedef struct {
    logic bank;
    int   len;
  } rd_ent_t;

  logic signed [DW-1:0] ram_i [2][2048];
  logic signed [DW-1:0] ram_q [2][2048];

  samp_t   exp_q[$];
  rd_ent_t rd_q[$];
  samp_t   e;
  int      rd_pos = 0;
  int      bank_idx = 0;
  int      m_pending = 0;
  int      free_cnt = 0;
  int      free_exp_total = 0;
  int      n_out = 0;
  bit      free_exp = 0;
  bit      zero_ok = 0;
  bit      prev_stall = 0;
  logic signed [DW-1:0] prev_i, prev_q;
  int      rdy_mode = 0;
  int      pat_cnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Synchronous symbol RAM pair, 1-cycle read latency
  always @(posedge CLK_Rd) begin
    if (Rd_en) begin
      Rd_data_I <= ram_i[Bank_Sel][Rd_addr];
      Rd_data_Q <= ram_q[Bank_Sel][Rd_addr];
    end
  end

  initial begin
    forever begin
      @(posedge CLK_Rd);
      #1;
      case (rdy_mode)
        0: Out_Ready = 1'b1;
        1: Out_Ready = ($urandom_range(0, 3) != 0);
        2: Out_Ready = 1'b0;
        default: begin
          Out_Ready = (pat_cnt == 0);
          pat_cnt = (pat_cnt + 1) % 3;
        end
      endcase
    end
  end

  task automatic model_push(input int len);
    int  n;
    logic b;
    n = (len > MAXS) ? MAXS : len;
    if (m_pending < 2) begin
      m_pending++;
      free_exp_total++;
      b = bank_idx[0];
      bank_idx++;
      for (int i = 0; i < n; i++)
        exp_q.push_back('{ram_i[b][i], ram_q[b][i], (i == n - 1)});
      if (n > 0) rd_q.push_back('{b, n});
    end
  endtask

  task automatic push_bank(input int len);
    @(posedge CLK_Rd);
    #1;
    Bank_Ready = 1'b1;
    Bank_Len   = AW'(len);
    model_push(len);
    @(posedge CLK_Rd);
    #1;
    Bank_Ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge CLK_Rd);
    #1;
    RST_Rd = 1'b1;
    repeat (2) @(posedge CLK_Rd);
    #1;
    RST_Rd = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || rd_q.size() != 0 || m_pending != 0) && c < budget) begin
      @(negedge CLK_Rd);
      c++;
    end
    check_val("idle_timeout", 64'(c < budget), 64'd1);
    @(negedge CLK_Rd);
  endtask

  // Monitor: compares reads, output samples and bank releases to the model
  initial begin
    forever begin
      @(negedge CLK_Rd);
      if (RST_Rd) begin
        exp_q.delete();
        rd_q.delete();
        rd_pos = 0;
        bank_idx = 0;
        m_pending = 0;
        free_exp = 0;
        prev_stall = 0;
        continue;
      end
      if (Bank_Free) free_cnt++;
      if (free_exp) begin
        check_val("bank_free", 64'(Bank_Free), 64'd1);
        m_pending--;
      end else if (Bank_Free && !zero_ok) begin
        check_val("spurious_free", 64'(Bank_Free), 64'd0);
      end
      free_exp = 0;
      if (prev_stall) begin
        check_val("hold_valid", 64'(Out_Valid), 64'd1);
        check_val("hold_i", 64'(Out_I), 64'(prev_i));
        check_val("hold_q", 64'(Out_Q), 64'(prev_q));
      end
      prev_stall = Out_Valid && !Out_Ready;
      prev_i = Out_I;
      prev_q = Out_Q;
      if (Rd_en) begin
        if (rd_q.size() == 0) begin
          check_val("rd_unexpected", 64'(Rd_en), 64'd0);
        end else begin
          check_val("rd_addr", 64'(Rd_addr), 64'(rd_pos));
          check_val("rd_bank", 64'(Bank_Sel), 64'(rd_q[0].bank));
          rd_pos++;
          if (rd_pos == rd_q[0].len) begin
            void'(rd_q.pop_front());
            rd_pos = 0;
          end
        end
      end
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          check_val("out_unexpected", 64'(Out_Valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("out_i", 64'(Out_I), 64'(e.i_v));
          check_val("out_q", 64'(Out_Q), 64'(e.q_v));
          check_val("out_last", 64'(Out_Last), 64'(e.last));
          if (e.last) free_exp = 1;
          n_out++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 2048; a++) begin
        ram_i[b][a] = DW'($urandom);
        ram_q[b][a] = DW'($urandom);
      end
    rdy_mode = 0;
    repeat (3) @(posedge CLK_Rd);
    #1;
    RST_Rd = 1'b0;
    @(negedge CLK_Rd);
    check_val("rst_valid", 64'(Out_Valid), 64'd0);
    check_val("rst_rd_en", 64'(Rd_en), 64'd0);
    check_val("rst_sel", 64'(Bank_Sel), 64'd0);
    check_val("rst_overrun", 64'(Overrun), 64'd0);
    check_val("rst_out_i", 64'(Out_I), 64'd0);

    // single bank of 4 with latency measurement
    @(posedge CLK_Rd);
    #1;
    Bank_Ready = 1'b1;
    Bank_Len   = AW'(4);
    model_push(4);
    @(negedge CLK_Rd);
    @(posedge CLK_Rd);
    #1;
    Bank_Ready = 1'b0;
    n = 1;
    @(negedge CLK_Rd);
    while (!Out_Valid && n < 20) begin
      @(negedge CLK_Rd);
      n++;
    end
    check_val("first_latency", 64'(n), 64'd4);
    wait_idle(200);
    check_val("sel_after_b4", 64'(Bank_Sel), 64'(bank_idx % 2));
    check_val("free_cnt_b4", 64'(free_cnt), 64'(free_exp_total));

    // two back-to-back banks from reset
    do_reset();
    free_cnt = 0;
    free_exp_total = 0;
    push_bank(3);
    push_bank(5);
    wait_idle(300);
    check_val("free_cnt_b35", 64'(free_cnt), 64'(free_exp_total));
    check_val("sel_after_b35", 64'(Bank_Sel), 64'(bank_idx % 2));

    // backpressure 1,0,0 pattern
    rdy_mode = 3;
    push_bank(6);
    wait_idle(300);
    rdy_mode = 0;

    // clamp
    base = n_out;
    push_bank(2047);
    wait_idle(3000);
    check_val("clamp_count", 64'(n_out - base), 64'd1200);

    // overrun with output stalled
    rdy_mode = 2;
    base = free_cnt;
    push_bank(3);
    push_bank(3);
    @(negedge CLK_Rd);
    check_val("overrun_early", 64'(Overrun), 64'd0);
    push_bank(3);
    @(negedge CLK_Rd);
    check_val("overrun_set", 64'(Overrun), 64'd1);
    repeat (5) @(negedge CLK_Rd);
    rdy_mode = 0;
    wait_idle(300);
    repeat (5) @(negedge CLK_Rd);
    check_val("overrun_sticky", 64'(Overrun), 64'd1);
    check_val("overrun_frees", 64'(free_cnt - base), 64'd2);
    do_reset();
    @(negedge CLK_Rd);
    check_val("overrun_clear", 64'(Overrun), 64'd0);

    // zero and one length banks
    base = free_cnt;
    zero_ok = 1;
    push_bank(0);
    repeat (6) @(negedge CLK_Rd);
    m_pending--;
    zero_ok = 0;
    check_val("zero_free", 64'(free_cnt - base), 64'd1);
    check_val("zero_sel", 64'(Bank_Sel), 64'(bank_idx % 2));
    base = n_out;
    push_bank(1);
    wait_idle(100);
    check_val("one_count", 64'(n_out - base), 64'd1);
    check_val("one_sel", 64'(Bank_Sel), 64'(bank_idx % 2));

    // randomized banks and backpressure
    rdy_mode = 1;
    for (int k = 0; k < 15; k++) begin
      n = 0;
      while (m_pending >= 2 && n < 500) begin
        @(negedge CLK_Rd);
        n++;
      end
      push_bank($urandom_range(1, 24));
      repeat ($urandom_range(0, 4)) @(posedge CLK_Rd);
    end
    wait_idle(3000);
    check_val("rand_sel", 64'(Bank_Sel), 64'(bank_idx % 2));
    rdy_mode = 0;

    // reset during sample 3 of 10
    do_reset();
    free_cnt = 0;
    base = n_out;
    push_bank(10);
    n = 0;
    while (n_out - base < 2 && n < 100) begin
      @(negedge CLK_Rd);
      n++;
    end
    @(posedge CLK_Rd);
    #1;
    RST_Rd = 1'b1;
    @(posedge CLK_Rd);
    #1;
    RST_Rd = 1'b0;
    @(negedge CLK_Rd);
    check_val("mid_rst_valid", 64'(Out_Valid), 64'd0);
    check_val("mid_rst_last", 64'(Out_Last), 64'd0);
    check_val("mid_rst_i", 64'(Out_I), 64'd0);
    check_val("mid_rst_q", 64'(Out_Q), 64'd0);
    check_val("mid_rst_rd_en", 64'(Rd_en), 64'd0);
    check_val("mid_rst_addr", 64'(Rd_addr), 64'd0);
    check_val("mid_rst_sel", 64'(Bank_Sel), 64'd0);
    check_val("mid_rst_free", 64'(Bank_Free), 64'd0);
    repeat (5) @(negedge CLK_Rd);
    check_val("mid_rst_no_free", 64'(free_cnt), 64'd0);
    push_bank(2);
    wait_idle(100);
    check_val("post_rst_free", 64'(free_cnt), 64'd1);
    check_val("post_rst_sel", 64'(Bank_Sel), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
